// File: rtl/led_chaser_ctrl.sv
// LED run-light engine: prescaler, speed divider and a four-mode pattern sequencer
// driving an LED_W-wide LED bank, with run/pause, single-step and a per-step strobe.
module led_chaser_ctrl #(
  parameter int LED_W      = 8,
  parameter int CNT_MAX    = 500_000,
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic             clk,
  input  logic             n_reset,
  input  logic             run,
  input  logic             step_i,
  input  logic [1:0]       mode,
  input  logic [1:0]       speed,
  output logic [LED_W-1:0] led,
  output logic             step_o
);

  localparam int CW = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam int FW = $clog2(LED_W + 1);

  typedef enum logic {DIR_UP, DIR_DOWN} dir_t;

  logic [LED_W-1:0] pat_q, pat_d;
  dir_t             dir_q, dir_d;
  logic [FW-1:0]    fill_q, fill_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [2:0]       div_q, div_d;
  logic [1:0]       mode_q, mode_d;
  logic             step_o_q, step_o_d;
  logic             base_tick;
  logic             adv;
  logic             advance;
  logic [2:0]       div_last;

  // The divider compares against the live speed, so an over-range count wraps on the next tick.
  assign div_last = (3'b001 << speed) - 3'd1;

  always_comb begin
    pat_d     = pat_q;
    dir_d     = dir_q;
    fill_d    = fill_q;
    cnt_d     = cnt_q;
    div_d     = div_q;
    mode_d    = mode;
    step_o_d  = 1'b0;
    base_tick = 1'b0;
    adv       = 1'b0;
    advance   = 1'b0;

    if (mode != mode_q) begin
      pat_d  = {{(LED_W-1){1'b0}}, 1'b1};
      dir_d  = DIR_UP;
      fill_d = FW'(1);
      cnt_d  = '0;
      div_d  = '0;
    end else begin
      if (run) begin
        if (cnt_q == CW'(CNT_MAX - 1)) begin
          cnt_d     = '0;
          base_tick = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      if (base_tick) begin
        if (div_q >= div_last) begin
          div_d = '0;
          adv   = 1'b1;
        end else begin
          div_d = div_q + 3'd1;
        end
      end

      advance = run ? adv : step_i;

      if (advance) begin
        step_o_d = 1'b1;
        case (mode_q)
          2'b00: pat_d = {pat_q[0], pat_q[LED_W-1:1]};
          2'b01: pat_d = {pat_q[LED_W-2:0], pat_q[LED_W-1]};
          2'b10: begin
            // Bounce off the end LEDs without lighting them twice in a row.
            if (dir_q == DIR_UP) begin
              if (pat_q[LED_W-1]) begin
                pat_d = pat_q >> 1;
                dir_d = DIR_DOWN;
              end else begin
                pat_d = pat_q << 1;
              end
            end else begin
              if (pat_q[0]) begin
                pat_d = pat_q << 1;
                dir_d = DIR_UP;
              end else begin
                pat_d = pat_q >> 1;
              end
            end
          end
          default: begin
            fill_d = (fill_q == FW'(LED_W)) ? '0 : fill_q + FW'(1);
            for (int i = 0; i < LED_W; i++) begin
              pat_d[i] = (FW'(i) < fill_d);
            end
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      pat_q    <= {{(LED_W-1){1'b0}}, 1'b1};
      dir_q    <= DIR_UP;
      fill_q   <= FW'(1);
      cnt_q    <= '0;
      div_q    <= '0;
      mode_q   <= mode;
      step_o_q <= 1'b0;
    end else begin
      pat_q    <= pat_d;
      dir_q    <= dir_d;
      fill_q   <= fill_d;
      cnt_q    <= cnt_d;
      div_q    <= div_d;
      mode_q   <= mode_d;
      step_o_q <= step_o_d;
    end
  end

  assign led    = ACTIVE_LOW ? ~pat_q : pat_q;
  assign step_o = step_o_q;

endmodule

// File: tb/tb_led_chaser_ctrl.sv
// Self-checking bench for led_chaser_ctrl (LED_W=4, CNT_MAX=4, ACTIVE_LOW=1) using
// directed per-feature tasks plus a randomized run against a position/fill reference model.
module tb_led_chaser_ctrl;

  localparam int W   = 4;
  localparam int CNT = 4;

  logic       clk;
  logic       n_reset;
  logic       run;
  logic       step_i;
  logic [1:0] mode;
  logic [1:0] speed;
  logic [3:0] led;
  logic       step_o;

  int checks   = 0;
  int failures = 0;

  // Reference model state: lit position, bounce direction, fill count, tick phase.
  int m_mode, m_phase, m_div, m_pos, m_fill;
  bit m_up, m_step;

  led_chaser_ctrl #(.LED_W(W), .CNT_MAX(CNT), .ACTIVE_LOW(1'b1)) dut (
    .clk     (clk),
    .n_reset (n_reset),
    .run     (run),
    .step_i  (step_i),
    .mode    (mode),
    .speed   (speed),
    .led     (led),
    .step_o  (step_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [3:0] exp_led();
    logic [3:0] p;
    if (m_mode == 3) p = 4'((1 << m_fill) - 1);
    else             p = 4'(1 << m_pos);
    return ~p;
  endfunction

  task automatic model_reset();
    m_mode  = int'(mode);
    m_phase = 0;
    m_div   = 0;
    m_pos   = 0;
    m_up    = 1'b1;
    m_fill  = 1;
    m_step  = 1'b0;
  endtask

  task automatic model_advance();
    case (m_mode)
      0: m_pos = (m_pos + W - 1) % W;
      1: m_pos = (m_pos + 1) % W;
      2: begin
        if (m_up) begin
          if (m_pos == W - 1) begin m_pos = W - 2; m_up = 1'b0; end
          else m_pos = m_pos + 1;
        end else begin
          if (m_pos == 0) begin m_pos = 1; m_up = 1'b1; end
          else m_pos = m_pos - 1;
        end
      end
      default: m_fill = (m_fill + 1) % (W + 1);
    endcase
  endtask

  // Advance the model with the inputs present at the coming edge, then sample after it.
  task automatic cyc();
    bit adv;
    adv = 1'b0;
    if (int'(mode) != m_mode) begin
      m_mode  = int'(mode);
      m_phase = 0;
      m_div   = 0;
      m_pos   = 0;
      m_up    = 1'b1;
      m_fill  = 1;
      m_step  = 1'b0;
    end else begin
      if (run) begin
        if (m_phase == CNT - 1) begin
          m_phase = 0;
          if (m_div + 1 >= (1 << speed)) begin m_div = 0; adv = 1'b1; end
          else m_div = m_div + 1;
        end else begin
          m_phase = m_phase + 1;
        end
      end
      m_step = run ? adv : step_i;
      if (m_step) model_advance();
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    n_reset = 1'b0; run = 1'b1; step_i = 1'b0; mode = 2'b00; speed = 2'b00;
    @(posedge clk); @(posedge clk); #1;
    checks++;
    if (led !== 4'b1110) begin failures++; $display("[TB] FAIL reset_led: got %b want %b", led, 4'b1110); end
    model_reset();
    @(negedge clk) n_reset = 1'b1;
    for (int c = 0; c < 4; c++) cyc();
    checks++;
    if (step_o !== 1'b1 || led !== 4'b0111) begin
      failures++; $display("[TB] FAIL prereset_step: got led=%b step_o=%b want 0111/1", led, step_o);
    end
    #2 n_reset = 1'b0;
    #1;
    checks++;
    if (led !== 4'b1110 || step_o !== 1'b0) begin
      failures++; $display("[TB] FAIL async_reset: got led=%b step_o=%b want 1110/0", led, step_o);
    end
    model_reset();
    @(negedge clk) n_reset = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      cyc();
      checks++;
      if (c < 4 && (led !== 4'b1110 || step_o !== 1'b0)) begin
        failures++; $display("[TB] FAIL post_reset_hold c=%0d: got led=%b step_o=%b want 1110/0", c, led, step_o);
      end else if (c == 4 && (led !== 4'b0111 || step_o !== 1'b1)) begin
        failures++; $display("[TB] FAIL post_reset_first_step: got led=%b step_o=%b want 0111/1", led, step_o);
      end
    end
  endtask

  // Waits for each strobe, checking the spacing and the new LED value.
  task automatic run_sequence(input string name, input logic [3:0] seq[], input int interval);
    for (int k = 0; k < seq.size(); k++) begin
      int c;
      bit got;
      c = 0; got = 1'b0;
      while (!got && c < 80) begin
        cyc();
        c++;
        got = step_o;
      end
      checks++;
      if (!got) begin failures++; $display("[TB] FAIL %s_timeout k=%0d: no step_o within %0d cycles", name, k, c); end
      checks++;
      if (c != interval) begin failures++; $display("[TB] FAIL %s_interval k=%0d: got %0d want %0d", name, k, c, interval); end
      checks++;
      if (led !== seq[k]) begin failures++; $display("[TB] FAIL %s_led k=%0d: got %b want %b", name, k, led, seq[k]); end
    end
  endtask

  task automatic change_mode(input logic [1:0] new_mode, input logic [1:0] new_speed);
    mode = new_mode; speed = new_speed;
    cyc();
    checks++;
    if (led !== 4'b1110 || step_o !== 1'b0) begin
      failures++; $display("[TB] FAIL reload_mode%0d: got led=%b step_o=%b want 1110/0", new_mode, led, step_o);
    end
  endtask

  task automatic test_rotate_right();
    run_sequence("rot_right", '{4'b1011, 4'b1101, 4'b1110, 4'b0111}, 4);
  endtask

  task automatic test_rotate_left();
    change_mode(2'b01, 2'b00);
    run_sequence("rot_left", '{4'b1101, 4'b1011, 4'b0111, 4'b1110}, 4);
  endtask

  task automatic test_ping_pong();
    change_mode(2'b10, 2'b00);
    run_sequence("ping_pong", '{4'b1101, 4'b1011, 4'b0111, 4'b1011, 4'b1101, 4'b1110, 4'b1101}, 4);
  endtask

  task automatic test_bar_fill();
    change_mode(2'b11, 2'b00);
    run_sequence("bar_fill", '{4'b1100, 4'b1000, 4'b0000, 4'b1111, 4'b1110}, 4);
  endtask

  task automatic test_speed();
    change_mode(2'b00, 2'b10);
    run_sequence("speed2", '{4'b0111, 4'b1011}, 16);
  endtask

  task automatic test_pause_step();
    run = 1'b0; speed = 2'b00;
    for (int c = 0; c < 20; c++) begin
      cyc();
      checks++;
      if (led !== 4'b1011 || step_o !== 1'b0) begin
        failures++; $display("[TB] FAIL pause_hold c=%0d: got led=%b step_o=%b want 1011/0", c, led, step_o);
      end
    end
    step_i = 1'b1; cyc(); step_i = 1'b0;
    checks++;
    if (led !== 4'b1101 || step_o !== 1'b1) begin
      failures++; $display("[TB] FAIL single_step: got led=%b step_o=%b want 1101/1", led, step_o);
    end
    cyc();
    checks++;
    if (led !== 4'b1101 || step_o !== 1'b0) begin
      failures++; $display("[TB] FAIL single_step_once: got led=%b step_o=%b want 1101/0", led, step_o);
    end
    run = 1'b1; step_i = 1'b1; cyc(); step_i = 1'b0;
    checks++;
    if (led !== 4'b1101 || step_o !== 1'b0) begin
      failures++; $display("[TB] FAIL step_ignored_running: got led=%b step_o=%b want 1101/0", led, step_o);
    end
  endtask

  task automatic test_mode_change_step();
    run = 1'b0; mode = 2'b01; step_i = 1'b1;
    cyc();
    step_i = 1'b0;
    checks++;
    if (led !== 4'b1110 || step_o !== 1'b0) begin
      failures++; $display("[TB] FAIL mode_change_priority: got led=%b step_o=%b want 1110/0", led, step_o);
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 1500; c++) begin
      run    = ($urandom % 4) != 0;
      step_i = ($urandom % 3) == 0;
      if ($urandom % 60 == 0) mode = 2'($urandom);
      if ($urandom % 40 == 0) speed = 2'($urandom % 3);
      cyc();
      checks++;
      if (led !== exp_led() || step_o !== m_step) begin
        failures++;
        $display("[TB] FAIL random c=%0d: got led=%b step_o=%b want %b/%b", c, led, step_o, exp_led(), m_step);
      end
    end
  endtask

  initial begin
    test_reset();
    test_rotate_right();
    test_rotate_left();
    test_ping_pong();
    test_bar_fill();
    test_speed();
    test_pause_step();
    test_mode_change_step();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/led_chaser_ctrl.md
Name: led_chaser_ctrl

Overview:
Parametrised LED run-light engine: one prescaler plus a pattern sequencer driving an LED_W-wide LED bank.
Four runtime-selectable modes: rotate right, rotate left, ping-pong, bar fill.
Also provides a speed divider, run/pause, single-step, and a per-step strobe.
Sits at board top level between the system clock/reset and the LED pins; the strobe is available to other status logic.

Parameters:
LED_W, 8, number of LEDs; legal range >= 2
CNT_MAX, 500_000, base tick period in clk cycles; legal range >= 1
ACTIVE_LOW, 1, 1 = LED lit when pin low (led = ~pat); 0 = lit when pin high (led = pat)

Ports:
clk  input  1  system clock
n_reset  input  1  asynchronous reset, active-low
run  input  1  1 = free-running; 0 = paused
step_i  input  1  single-cycle pulse; advances one step while paused
mode  input  2  00 rotate right, 01 rotate left, 10 ping-pong, 11 bar fill
speed  input  2  step every 2^speed base ticks
led  output  LED_W  LED drive, polarity per ACTIVE_LOW
step_o  output  1  one-cycle pulse, high in the first cycle a new pattern is on led

Behaviour:
- Reset (async, n_reset low), all state registered on posedge clk:
  - Internal logical pattern pat = 1, so LED0 is lit and led = ACTIVE_LOW ? ~1 : 1.
  - Ping-pong direction dir = up (toward MSB); fill count = 1.
  - Prescaler = 0; speed divider = 0; step_o = 0; mode_q = mode.
- Prescaler:
  - While run = 1, counts 0..CNT_MAX-1 and wraps to 0.
  - base_tick is asserted when the count is CNT_MAX-1. With CNT_MAX = 1, base_tick is true every cycle.
  - While run = 0, the prescaler and divider hold their values.
- Speed divider: counts base_ticks modulo 2^speed. adv is asserted on the base_tick that completes the count.
  - speed = 0: every base_tick.
  - speed = 3: every 8th base_tick.
  - A speed change takes effect on the next base_tick. The divider is compared against the new modulus; if it is already >= 2^speed, it wraps on the next base_tick.
- Advance source:
  - adv while run = 1.
  - Otherwise step_i while run = 0.
  - step_i while run = 1 is ignored.
- On advance, the pattern register updates on that clk edge and step_o = 1 for exactly that following cycle.
- Step rules:
  - 00 rotate right: pat = {pat[0], pat[LED_W-1:1]}.
  - 01 rotate left: pat = {pat[LED_W-2:0], pat[LED_W-1]}.
  - 10 ping-pong: one-hot position moves by one in dir.
    - At bit LED_W-1 with dir = up: move to LED_W-2 and set dir = down.
    - At bit 0 with dir = down: move to 1 and set dir = up.
    - End LEDs are never repeated.
  - 11 bar fill: fill counts 1, 2, ..., LED_W, 0, 1, ...; pat = (1 << fill) - 1.
    - fill = LED_W gives all lit; fill = 0 gives all dark.
- Mode change (mode != mode_q):
  - On the next clk edge, reload pat = 1, dir = up, fill = 1, and clear the prescaler and divider.
  - mode_q updates and step_o stays 0.
  - Mode change takes priority over a simultaneous advance or step_i.
- The pattern never becomes all-zero in modes 00/01/10; one-hot is preserved.
- Reset mid-sequence returns immediately (asynchronously) to the reset state.

Test Plan:
1. Common bench settings for all cases: LED_W = 4, CNT_MAX = 4, ACTIVE_LOW = 1.
2. Reset check: assert n_reset low mid-run -> led = 4'b1110 at once; step_o = 0; after release, the first step occurs 4 cycles later.
3. Rotate right: mode = 00, speed = 0, run = 1 -> led 1110 → 0111 → 1011 → 1101 → 1110, changing every 4 clk; step_o pulses once per change.
4. Rotate left: mode = 01 -> led 1110 → 1101 → 1011 → 0111 → 1110. Ping-pong: mode = 10 -> lit bit sequence 0,1,2,3,2,1,0,1, with no repeat at the ends.
5. Bar fill: mode = 11 -> led 1110 → 1100 → 1000 → 0000 → 1111 → 1110. Speed: speed = 2 -> steps 16 clk apart.
6. Pause, step and mode change:
   - run = 0 -> led holds indefinitely.
   - One step_i pulse -> exactly one advance plus one step_o.
   - step_i with run = 1 -> no extra step.
   - Change mode mid-sequence together with step_i -> led reloads to 1110 and step_o stays 0.
